// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the memory stage: op codes, FSM states and op classification helpers.
package mem_defs;

  localparam int MEM_XLEN  = 32;
  localparam int MEM_OP_W  = 4;

  typedef enum logic [MEM_OP_W-1:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  function automatic logic is_load(input logic [MEM_OP_W-1:0] op);
    return (op >= 4'd1) && (op <= 4'd5);
  endfunction

  function automatic logic is_store(input logic [MEM_OP_W-1:0] op);
    return (op >= 4'd6) && (op <= 4'd8);
  endfunction

  // Codes 9..15 fall through to 0, so unknown ops never look misaligned.
  function automatic logic is_misaligned(input logic [MEM_OP_W-1:0] op, input logic [1:0] off);
    logic mis;
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: mis = off[0];
      MEM_LW, MEM_SW:          mis = (off != 2'b00);
      default:                 mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Byte-lane steering: store replication and byte enables, load extraction and extension.
module lsu_align
  import mem_defs::*;
(
  input  logic [MEM_OP_W-1:0] st_op,
  input  logic [1:0]          st_off,
  input  logic [MEM_XLEN-1:0] sdata,
  output logic [MEM_XLEN-1:0] wdata,
  output logic [3:0]          be,
  input  logic [MEM_OP_W-1:0] ld_op,
  input  logic [1:0]          ld_off,
  input  logic [MEM_XLEN-1:0] rdata,
  output logic [MEM_XLEN-1:0] ldata
);

  logic [MEM_XLEN-1:0] shifted_s;

  assign shifted_s = rdata >> {ld_off, 3'b000};

  // Lane enables follow access size for loads and stores alike; data replicated only for stores.
  always_comb begin
    wdata = 32'h0000_0000;
    be    = 4'b0000;
    case (st_op)
      MEM_SB:           begin wdata = {4{sdata[7:0]}};  be = 4'b0001 << st_off; end
      MEM_SH:           begin wdata = {2{sdata[15:0]}}; be = st_off[1] ? 4'b1100 : 4'b0011; end
      MEM_SW:           begin wdata = sdata;            be = 4'b1111; end
      MEM_LB, MEM_LBU:  be = 4'b0001 << st_off;
      MEM_LH, MEM_LHU:  be = st_off[1] ? 4'b1100 : 4'b0011;
      MEM_LW:           be = 4'b1111;
      default:          be = 4'b0000;
    endcase
  end

  // Load result extraction with sign or zero extension.
  always_comb begin
    ldata = 32'h0000_0000;
    case (ld_op)
      MEM_LB:  ldata = {{24{shifted_s[7]}}, shifted_s[7:0]};
      MEM_LBU: ldata = {24'h00_0000, shifted_s[7:0]};
      MEM_LH:  ldata = {{16{shifted_s[15]}}, shifted_s[15:0]};
      MEM_LHU: ldata = {16'h0000, shifted_s[15:0]};
      MEM_LW:  ldata = rdata;
      default: ldata = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory stage: ALU pass-through, load/store sequencing onto a req/ack bus, stall and misalign.
module mem_lsu
  import mem_defs::*;
#(
  parameter int XLEN = 32,
  parameter int BE_W = XLEN / 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [4:0]      reg_waddr_i,
  input  logic            reg_we_i,
  input  logic [XLEN-1:0] reg_wdata_i,
  input  logic [3:0]      mem_op_i,
  input  logic [XLEN-1:0] mem_sdata_i,
  output logic [4:0]      reg_waddr_o,
  output logic            reg_we_o,
  output logic [XLEN-1:0] reg_wdata_o,
  output logic            stall_o,
  output logic            misalign_o,
  output logic            dbus_req_o,
  output logic            dbus_we_o,
  output logic [XLEN-1:0] dbus_addr_o,
  output logic [XLEN-1:0] dbus_wdata_o,
  output logic [BE_W-1:0] dbus_be_o,
  input  logic [XLEN-1:0] dbus_rdata_i,
  input  logic            dbus_ack_i
);

  lsu_state_e      state_r, state_nxt_s;
  logic [3:0]      op_r;
  logic [1:0]      off_r;
  logic [4:0]      waddr_r;
  logic [XLEN-1:0] result_r;
  logic [XLEN-1:0] fmt_wdata_s, fmt_ldata_s;
  logic [BE_W-1:0] fmt_be_s;
  logic            is_mem_s, mis_s, start_s;

  assign is_mem_s = is_load(mem_op_i) || is_store(mem_op_i);
  assign mis_s    = is_mem_s && is_misaligned(mem_op_i, reg_wdata_i[1:0]);
  assign start_s  = (state_r == ST_IDLE) && is_mem_s && !mis_s;

  // Store side formats the incoming op; load side formats against the latched op and offset.
  lsu_align u_align (
    .st_op  (mem_op_i),
    .st_off (reg_wdata_i[1:0]),
    .sdata  (mem_sdata_i),
    .wdata  (fmt_wdata_s),
    .be     (fmt_be_s),
    .ld_op  (op_r),
    .ld_off (off_r),
    .rdata  (dbus_rdata_i),
    .ldata  (fmt_ldata_s)
  );

  // Next-state and MEM/WB / stall outputs.
  always_comb begin
    state_nxt_s = state_r;
    reg_waddr_o = reg_waddr_i;
    reg_we_o    = reg_we_i;
    reg_wdata_o = reg_wdata_i;
    stall_o     = 1'b0;
    misalign_o  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (mis_s) begin
          misalign_o  = 1'b1;
          reg_we_o    = 1'b0;
          state_nxt_s = ST_IDLE;
        end else if (start_s) begin
          stall_o     = 1'b1;
          reg_we_o    = 1'b0;
          state_nxt_s = ST_BUSY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        stall_o  = 1'b1;
        reg_we_o = 1'b0;
        if (dbus_ack_i) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
        if (is_load(op_r)) begin
          reg_we_o    = 1'b1;
          reg_waddr_o = waddr_r;
          reg_wdata_o = result_r;
        end else begin
          reg_we_o = 1'b0;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        reg_we_o    = 1'b0;
      end
    endcase
  end

  // State, latched request and load result registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= ST_IDLE;
      dbus_req_o   <= 1'b0;
      dbus_we_o    <= 1'b0;
      dbus_addr_o  <= 32'h0000_0000;
      dbus_wdata_o <= 32'h0000_0000;
      dbus_be_o    <= 4'b0000;
      result_r     <= 32'h0000_0000;
      op_r         <= MEM_NONE;
      off_r        <= 2'b00;
      waddr_r      <= 5'd0;
    end else begin
      state_r <= state_nxt_s;
      if (start_s) begin
        dbus_req_o   <= 1'b1;
        dbus_we_o    <= is_store(mem_op_i);
        dbus_addr_o  <= {reg_wdata_i[XLEN-1:2], 2'b00};
        dbus_wdata_o <= fmt_wdata_s;
        dbus_be_o    <= fmt_be_s;
        op_r         <= mem_op_i;
        off_r        <= reg_wdata_i[1:0];
        waddr_r      <= reg_waddr_i;
      end else if ((state_r == ST_BUSY) && dbus_ack_i) begin
        dbus_req_o <= 1'b0;
        result_r   <= fmt_ldata_s;
      end
    end
  end

endmodule
